// File: rtl/mmc3_irq_counter_if.sv
// Register-write bus, PPU/CPU timing inputs and IRQ outputs of the MMC3 scanline IRQ engine.
// The mapper side drives as master; the IRQ engine attaches as slave.
interface mmc3_irq_counter_if;
   logic       cpu_m2;
   logic       ppu_a12;
   logic       reg_we;
   logic [1:0] reg_sel;
   logic [7:0] reg_data;
   logic       irq_n;
   logic       a12_rise;
   logic [7:0] cnt;

   modport master (
      output cpu_m2, ppu_a12, reg_we, reg_sel, reg_data,
      input  irq_n, a12_rise, cnt
   );

   modport slave (
      input  cpu_m2, ppu_a12, reg_we, reg_sel, reg_data,
      output irq_n, a12_rise, cnt
   );
endinterface

// File: rtl/mmc3_irq_counter.sv
// MMC3 scanline IRQ engine: M2-filtered PPU A12 edge detector feeding an 8-bit
// reloadable down-counter that pulls irq_n low when it reaches zero while enabled.
module mmc3_irq_counter #(
   parameter int FILT_M2  = 3,
   parameter int ALT_ZERO = 0
) (
   input logic               clk,
   input logic               rst,
   mmc3_irq_counter_if.slave bus
);

   localparam logic [2:0] FILT = 3'(FILT_M2);

   logic       r_m2Q;
   logic       r_a12Q;
   logic [2:0] r_lowCnt;
   logic       r_a12Rise;
   logic [7:0] r_cnt;
   logic [7:0] r_latch;
   logic       r_reload;
   logic       r_irqEn;
   logic       r_irqN;

   logic       w_m2Fall;
   logic       w_rise;
   logic       w_doReload;
   logic [7:0] w_newCnt;
   logic       w_zero;
   logic       w_fire;
   logic       w_wrLatch;
   logic       w_wrReload;
   logic       w_wrAck;
   logic       w_wrEnable;
   logic       w_enNext;

   assign w_m2Fall = r_m2Q & ~bus.cpu_m2;
   assign w_rise   = bus.ppu_a12 & ~r_a12Q & (r_lowCnt == FILT);

   assign w_wrLatch  = bus.reg_we & (bus.reg_sel == 2'd0);
   assign w_wrReload = bus.reg_we & (bus.reg_sel == 2'd1);
   assign w_wrAck    = bus.reg_we & (bus.reg_sel == 2'd2);
   assign w_wrEnable = bus.reg_we & (bus.reg_sel == 2'd3);

   // Counter update always works from pre-write state; register writes override afterwards.
   assign w_doReload = (r_cnt == 8'd0) | r_reload;
   assign w_newCnt   = w_doReload ? r_latch : (r_cnt - 8'd1);
   assign w_zero     = (w_newCnt == 8'd0);
   assign w_fire     = (ALT_ZERO != 0)
                     ? (w_zero & ((r_cnt == 8'd1) | (w_doReload & (r_latch != 8'd0))))
                     : w_zero;

   assign w_enNext = w_wrEnable ? 1'b1 : (w_wrAck ? 1'b0 : r_irqEn);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_m2Q     <= 1'b0;
         r_a12Q    <= 1'b0;
         r_lowCnt  <= 3'd0;
         r_a12Rise <= 1'b0;
      end else begin
         r_m2Q     <= bus.cpu_m2;
         r_a12Q    <= bus.ppu_a12;
         r_a12Rise <= w_rise;
         if (bus.ppu_a12) begin
            r_lowCnt <= 3'd0;
         end else if (w_m2Fall && (r_lowCnt != FILT)) begin
            r_lowCnt <= r_lowCnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= 8'd0;
         r_reload <= 1'b0;
         r_latch  <= 8'd0;
      end else begin
         if (w_wrReload) begin
            r_cnt    <= 8'd0;
            r_reload <= 1'b1;
         end else if (w_rise) begin
            r_cnt    <= w_newCnt;
            r_reload <= 1'b0;
         end
         if (w_wrLatch) begin
            r_latch <= bus.reg_data;
         end
      end
   end

   // irq_n is sticky low until acknowledged; an ack in the same cycle as a fire wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_irqEn <= 1'b0;
         r_irqN  <= 1'b1;
      end else begin
         r_irqEn <= w_enNext;
         if (w_wrAck) begin
            r_irqN <= 1'b1;
         end else if (w_rise && w_fire && w_enNext) begin
            r_irqN <= 1'b0;
         end
      end
   end

   assign bus.irq_n    = r_irqN;
   assign bus.a12_rise = r_a12Rise;
   assign bus.cnt      = r_cnt;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Directed bench for mmc3_irq_counter; drives a "new" (ALT_ZERO=0) and an "old"
// (ALT_ZERO=1) instance with identical stimulus and checks both against hand-computed values.
module tb_mmc3_irq_counter;

   localparam int FILT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [1:0] sel;
   logic [7:0] data;
   logic       m2;
   logic       a12;

   int vecCount  = 0;
   int missCount = 0;

   mmc3_irq_counter_if busA ();
   mmc3_irq_counter_if busB ();

   assign busA.cpu_m2   = m2;
   assign busA.ppu_a12  = a12;
   assign busA.reg_we   = we;
   assign busA.reg_sel  = sel;
   assign busA.reg_data = data;
   assign busB.cpu_m2   = m2;
   assign busB.ppu_a12  = a12;
   assign busB.reg_we   = we;
   assign busB.reg_sel  = sel;
   assign busB.reg_data = data;

   mmc3_irq_counter #(.FILT_M2(FILT), .ALT_ZERO(0)) dutA (.clk(clk), .rst(rst), .bus(busA));
   mmc3_irq_counter #(.FILT_M2(FILT), .ALT_ZERO(1)) dutB (.clk(clk), .rst(rst), .bus(busB));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge, outputs are sampled at the same point.
   task automatic applyStimulus(input logic iWe, input logic [1:0] iSel, input logic [7:0] iData,
                                input logic iM2, input logic iA12);
      we   = iWe;
      sel  = iSel;
      data = iData;
      m2   = iM2;
      a12  = iA12;
      @(posedge clk);
      #1;
   endtask

   task automatic regWrite(input logic [1:0] iSel, input logic [7:0] iData);
      applyStimulus(1'b1, iSel, iData, 1'b0, 1'b0);
      we = 1'b0;
   endtask

   task automatic m2Falls(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
         applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      end
   endtask

   task automatic checkState(input string tag, input int expCnt, input int expIrqA, input int expIrqB);
      checkOutput({tag, "/cntA"}, busA.cnt, 8'(expCnt));
      checkOutput({tag, "/cntB"}, busB.cnt, 8'(expCnt));
      checkOutput({tag, "/irqA"}, {7'd0, busA.irq_n}, 8'(expIrqA));
      checkOutput({tag, "/irqB"}, {7'd0, busB.irq_n}, 8'(expIrqB));
   endtask

   // Qualified A12 rise, optionally with a register write landing on the same edge.
   task automatic doRise(input string tag, input logic wEn, input logic [1:0] wSel, input logic [7:0] wData,
                         input int expCnt, input int expIrqA, input int expIrqB);
      m2Falls(FILT);
      applyStimulus(wEn, wSel, wData, 1'b0, 1'b1);
      checkOutput({tag, "/riseA"}, {7'd0, busA.a12_rise}, 8'd1);
      checkOutput({tag, "/riseB"}, {7'd0, busB.a12_rise}, 8'd1);
      checkState(tag, expCnt, expIrqA, expIrqB);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      checkOutput({tag, "/riseEnd"}, {7'd0, busA.a12_rise}, 8'd0);
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      checkState("reset", 0, 1, 1);
      checkOutput("reset/rise", {7'd0, busA.a12_rise}, 8'd0);
      rst = 1'b1;

      regWrite(2'd0, 8'd3);
      regWrite(2'd1, 8'd0);
      regWrite(2'd3, 8'd0);
      checkState("setup", 0, 1, 1);
      doRise("seq1", 1'b0, 2'd0, 8'd0, 3, 1, 1);
      doRise("seq2", 1'b0, 2'd0, 8'd0, 2, 1, 1);
      doRise("seq3", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("seq4", 1'b0, 2'd0, 8'd0, 0, 0, 0);
      doRise("seq5", 1'b0, 2'd0, 8'd0, 3, 0, 0);

      m2Falls(2);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
      checkOutput("short/riseA", {7'd0, busA.a12_rise}, 8'd0);
      checkOutput("short/cntA", busA.cnt, 8'd3);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      m2Falls(1);
      doRise("long", 1'b0, 2'd0, 8'd0, 2, 0, 0);

      regWrite(2'd2, 8'd0);
      checkState("ack", 2, 1, 1);
      doRise("dis1", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("dis0", 1'b0, 2'd0, 8'd0, 0, 1, 1);
      regWrite(2'd3, 8'd0);
      doRise("en3", 1'b0, 2'd0, 8'd0, 3, 1, 1);
      doRise("en2", 1'b0, 2'd0, 8'd0, 2, 1, 1);
      doRise("en1", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("en0", 1'b0, 2'd0, 8'd0, 0, 0, 0);

      regWrite(2'd2, 8'd0);
      regWrite(2'd0, 8'd0);
      regWrite(2'd1, 8'd0);
      regWrite(2'd3, 8'd0);
      doRise("latch0a", 1'b0, 2'd0, 8'd0, 0, 0, 1);
      regWrite(2'd2, 8'd0);
      checkState("latch0ack", 0, 1, 1);
      regWrite(2'd3, 8'd0);
      doRise("latch0b", 1'b0, 2'd0, 8'd0, 0, 0, 1);
      regWrite(2'd2, 8'd0);

      regWrite(2'd0, 8'd1);
      regWrite(2'd3, 8'd0);
      regWrite(2'd1, 8'd0);
      doRise("load1", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("ackRace", 1'b1, 2'd2, 8'd0, 0, 1, 1);
      doRise("reload1", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("enRace", 1'b1, 2'd3, 8'd0, 0, 0, 0);
      regWrite(2'd2, 8'd0);

      regWrite(2'd0, 8'd5);
      doRise("load5", 1'b0, 2'd0, 8'd0, 5, 1, 1);
      doRise("rldRace", 1'b1, 2'd1, 8'd0, 0, 1, 1);
      doRise("rldNext", 1'b0, 2'd0, 8'd0, 5, 1, 1);

      regWrite(2'd3, 8'd0);
      doRise("pre4", 1'b0, 2'd0, 8'd0, 4, 1, 1);
      doRise("pre3", 1'b0, 2'd0, 8'd0, 3, 1, 1);
      doRise("pre2", 1'b0, 2'd0, 8'd0, 2, 1, 1);
      doRise("pre1", 1'b0, 2'd0, 8'd0, 1, 1, 1);
      doRise("pre0", 1'b0, 2'd0, 8'd0, 0, 0, 0);
      doRise("pre5", 1'b0, 2'd0, 8'd0, 5, 0, 0);
      rst = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      rst = 1'b1;
      checkState("midReset", 0, 1, 1);
      checkOutput("midReset/rise", {7'd0, busA.a12_rise}, 8'd0);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
      checkOutput("postRst/riseA", {7'd0, busA.a12_rise}, 8'd0);
      checkOutput("postRst/riseB", {7'd0, busB.a12_rise}, 8'd0);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      doRise("postRst", 1'b0, 2'd0, 8'd0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
